seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed controller for the 8-digit common-anode 7-segment display. It holds eight 5-bit digit codes (hex nibble plus decimal point) in a shadow/active register pair and scans digits 0..7 with a programmable dwell time and inter-digit blanking. It drives active-low one-hot digit selects and active-low segment patterns. It sits between the host logic that writes digit values and the display pins.

Parameters:
DIV, 1000, clks cycles each digit is lit (SHOW dwell); legal range >= 1
BLANK, 2, clks cycles of all-off between digits (ghosting guard); 0 = no blanking
CW, 16, width of the internal dwell/blank counter; must hold max(DIV, BLANK)

Ports:
clks  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low = display dark
wr_en  in  1  write strobe into shadow register
wr_addr  in  3  digit index for write (0 = rightmost, sel bit 0)
wr_data  in  5  {dp, hex[3:0]}
commit_req  in  1  request shadow->active copy at next frame boundary
digit_en  in  8  per-digit lit mask; 0 = slot kept but blanked
sel  out  8  digit select, active-low one-hot, FF = none
seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
commit_pend  out  1  commit requested, not yet applied
frame_tick  out  1  1-cycle pulse at end of digit 7 SHOW

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, cnt=0, sel=FF, seg=FF, commit_pend=0, frame_tick=0, all shadow and active regs = 0.
- All outputs are registered. sel/seg change on the same edge as the state change.
- FSM IDLE -> BLANK -> SHOW -> BLANK ...
  - IDLE: sel=FF, seg=FF. When en=1, go to BLANK, or go straight to SHOW if BLANK=0.
  - BLANK: sel=FF, seg=FF for BLANK cycles, then SHOW.
  - SHOW: sel=~(1<<idx), seg=decode(active[idx]) for DIV cycles. If digit_en[idx]=0, sel=FF and seg=FF, but the slot duration is unchanged.
  - At the end of SHOW: idx increments, wrapping 7->0. Next state is BLANK, or SHOW if BLANK=0.
- Frame length = 8*(BLANK+DIV) cycles.
- Decode (dp=0, bit7=1): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E. dp=1 clears bit7.
- wr_en=1: shadow[wr_addr] <= wr_data on the next edge. The active regs are unaffected.
- commit_req=1 sets commit_pend on the next edge. commit_req while pending has no further effect.
- Frame boundary = last SHOW cycle with idx=7.
  - frame_tick pulses in the cycle after that edge.
  - If commit_pend=1 at that edge: active <= shadow (all 8 digits atomically) and commit_pend <= 0.
- Simultaneous events:
  - commit_req on the boundary edge with commit_pend=0: sets pend; the copy happens at the next boundary.
  - wr_en on the boundary edge during a copy: the copy takes the pre-write shadow value; the write lands in shadow only.
- en deasserted at any time: the next edge forces IDLE, sel=FF, seg=FF, idx=0, cnt=0. Shadow, active and commit_pend are retained. Re-enable restarts at digit 0 in BLANK.
- digit_en changes take effect at the next SHOW entry only, never mid-dwell.

Optional Feature:
SEG7_LZB_EN:
- Defined: leading-zero blanking. For idx 7..1, a digit whose active code is 0x00 (hex 0, dp 0) is blanked (sel=FF, seg=FF) when every higher-index active code is also 0x00. Digit 0 is never blanked by this rule. Timing is unchanged.
- Undefined: all enabled digits are shown as decoded, including leading zeros.

Test Plan:
- DIV=4, BLANK=1, reset then en=1, digit_en=FF, all digits 0 -> sel sequence FF, FE x4, FF, FD x4, ... 7F x4, repeating; seg=C0 during every SHOW; frame_tick every 40 cycles.
- Write shadow[3]={1,0x5}, no commit -> seg stays C0 at sel=F7. Pulse commit_req -> commit_pend=1. At next frame boundary commit_pend=0; in the following frame seg=12 when sel=F7.
- commit_req asserted on the boundary edge plus wr_en to shadow[0]=0x08 on the same edge -> copy deferred one frame; then seg=80 at sel=FE.
- en dropped mid-dwell of digit 4 -> next edge sel=FF, seg=FF. en re-raised -> one BLANK cycle then sel=FE.
- digit_en=0xFE -> sel=FF during slots 1..7, slot timing unchanged; sel=FE only in slot 0.
- SEG7_LZB_EN defined, active = {0,0,0,0,0,0x1,0,0x3} (digit7..0) -> digits 7..3 dark, digit 2 shows F9, digit 1 shows C0, digit 0 shows B0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit multiplexed 7-segment scan controller with shadow/active digit registers.
// Optional leading-zero blanking enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2,
  parameter int CW    = 16
) (
  input  logic       clks,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit_req,
  input  logic [7:0] digit_en,
  output logic [7:0] sel,
  output logic [7:0] seg,
  output logic       commit_pend,
  output logic       frame_tick
);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  state_t          state;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic [7:0][4:0] shadow;
  logic [7:0][4:0] active;

  logic [7:0][4:0] act_nxt;
  logic [7:0]      lz_dark;
  logic            boundary;
  logic [2:0]      nidx;
  logic            lit;
  logic [7:0]      show_sel;
  logic [7:0]      show_seg;

  function automatic logic [7:0] decode(input logic [4:0] code);
    logic [7:0] p;
    case (code[3:0])
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    p[7] = ~code[4];
    return p;
  endfunction

  assign boundary = en && (state == ST_SHOW) && (idx == 3'd7) && (cnt == DIV_LAST);

  // A SHOW entry on the frame-boundary edge must already see the committed digits.
  always_comb begin
    act_nxt = (boundary && commit_pend) ? shadow : active;
    lz_dark = '0;
`ifdef SEG7_LZB_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      for (int k = 7; k >= 1; k--) begin
        all_zero   = all_zero && (act_nxt[k] == 5'd0);
        lz_dark[k] = all_zero;
      end
    end
`endif
    nidx     = (state == ST_SHOW) ? idx + 3'd1 : idx;
    lit      = digit_en[nidx] && !lz_dark[nidx];
    show_sel = lit ? ~(8'd1 << nidx) : 8'hFF;
    show_seg = lit ? decode(act_nxt[nidx]) : 8'hFF;
  end

  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      cnt         <= '0;
      sel         <= 8'hFF;
      seg         <= 8'hFF;
      commit_pend <= 1'b0;
      frame_tick  <= 1'b0;
      shadow      <= '0;
      active      <= '0;
    end else begin
      frame_tick <= boundary;
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (boundary && commit_pend) begin
        active      <= shadow;
        commit_pend <= 1'b0;
      end else if (commit_req) begin
        commit_pend <= 1'b1;
      end

      if (!en) begin
        state <= ST_IDLE;
        idx   <= 3'd0;
        cnt   <= '0;
        sel   <= 8'hFF;
        seg   <= 8'hFF;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (BLANK == 0) begin
              state <= ST_SHOW;
              sel   <= show_sel;
              seg   <= show_seg;
            end else begin
              state <= ST_BLANK;
            end
          end
          ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= ST_SHOW;
              cnt   <= '0;
              sel   <= show_sel;
              seg   <= show_seg;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_SHOW: begin
            if (cnt == DIV_LAST) begin
              idx <= idx + 3'd1;
              cnt <= '0;
              if (BLANK == 0) begin
                sel <= show_sel;
                seg <= show_seg;
              end else begin
                state <= ST_BLANK;
                sel   <= 8'hFF;
                seg   <= 8'hFF;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            sel   <= 8'hFF;
            seg   <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl against a frame-arithmetic reference model.
// Model honours SEG7_LZB_EN when defined.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int L     = DIV + BLANK;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clks = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic       commit_req = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] sel;
  logic [7:0] seg;
  logic       commit_pend;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clks = ~clks;

  seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .CW(16)) dut (
    .clks(clks), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit_req(commit_req), .digit_en(digit_en),
    .sel(sel), .seg(seg), .commit_pend(commit_pend), .frame_tick(frame_tick)
  );

  // Reference state: time since enable, expressed as a plain cycle count.
  bit         m_run;
  int         m_c;
  logic [4:0] m_sh [8];
  logic [4:0] m_act [8];
  logic       m_pend, m_tick;
  logic [7:0] m_den, m_sel, m_seg;
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] exp_seg(input logic [4:0] code);
    logic [7:0] r;
    r = hex_tab[code[3:0]];
    r[7] = ~code[4];
    return r;
  endfunction

  function automatic bit lz_dark(input int k);
    if (!LZB || k == 0) return 1'b0;
    for (int j = k; j < 8; j++) if (m_act[j] != 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit next_is_boundary();
    return m_run && en && ((m_c / L) % 8 == 7) && (m_c % L == L - 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_c = 0; m_pend = 0; m_tick = 0;
    m_den = 8'hFF; m_sel = 8'hFF; m_seg = 8'hFF;
    for (int i = 0; i < 8; i++) begin m_sh[i] = 5'd0; m_act[i] = 5'd0; end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit bnd;
    int slot, ph;
    bnd = next_is_boundary();
    m_tick = bnd;
    if (bnd && m_pend) begin
      for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end else if (commit_req) begin
      m_pend = 1;
    end
    if (wr_en) m_sh[wr_addr] = wr_data;
    if (!en) m_run = 0;
    else if (!m_run) begin m_run = 1; m_c = 0; end
    else m_c++;
    m_sel = 8'hFF; m_seg = 8'hFF;
    if (m_run) begin
      slot = (m_c / L) % 8;
      ph   = m_c % L;
      if (ph >= BLANK) begin
        if (ph == BLANK) m_den = digit_en;
        if (m_den[slot] && !lz_dark(slot)) begin
          m_sel = ~(8'd1 << slot);
          m_seg = exp_seg(m_act[slot]);
        end
      end
    end
    @(posedge clks);
    #1;
    check("sel", sel, m_sel);
    check("seg", seg, m_seg);
    check("commit_pend", {7'd0, commit_pend}, {7'd0, m_pend});
    check("frame_tick", {7'd0, frame_tick}, {7'd0, m_tick});
  endtask

  task automatic run_to_boundary();
    int n;
    n = 0;
    while (!next_is_boundary() && n < 200) begin step(); n++; end
    checks++;
    assert (next_is_boundary()) else begin
      errors++;
      $error("FAIL boundary_wait got %0d cycles expected <200", n);
    end
  endtask

  task automatic run_to_slot(input int s, input int p);
    int n;
    n = 0;
    while (!(m_run && (m_c / L) % 8 == s && m_c % L == p) && n < 200) begin step(); n++; end
    checks++;
    assert (m_run && (m_c / L) % 8 == s && m_c % L == p) else begin
      errors++;
      $error("FAIL slot_wait got %0d cycles expected <200", n);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_sel", sel, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_pend", {7'd0, commit_pend}, 8'd0);
    check("rst_tick", {7'd0, frame_tick}, 8'd0);
    @(posedge clks); #1;
    rst_n = 1'b1;

    // All digits zero, steady scan
    en = 1'b1;
    repeat (85) step();

    // Shadow write without commit, then commit
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h15;
    step();
    wr_en = 1'b0;
    repeat (50) step();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    check("pend_after_req", {7'd0, commit_pend}, 8'd1);
    repeat (90) step();

    // Commit request and write coinciding with the boundary edge
    run_to_boundary();
    commit_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
    step();
    commit_req = 1'b0; wr_en = 1'b0;
    check("pend_deferred", {7'd0, commit_pend}, 8'd1);
    repeat (90) step();

    // Drop enable mid-dwell of digit 4, then re-enable
    run_to_slot(4, BLANK + 1);
    en = 1'b0;
    step();
    check("en_drop_sel", sel, 8'hFF);
    check("en_drop_seg", seg, 8'hFF);
    repeat (3) step();
    en = 1'b1;
    step();
    check("reen_blank", sel, 8'hFF);
    step();
    check("reen_digit0", sel, 8'hFE);
    repeat (10) step();

    // Only digit 0 lit
    digit_en = 8'hFE;
    repeat (90) step();
    digit_en = 8'hFF;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      en         = ($urandom_range(0, 59) != 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 3'($urandom);
      wr_data    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      commit_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) digit_en = 8'($urandom);
      step();
    end
    en = 1'b1; wr_en = 1'b0; commit_req = 1'b0; digit_en = 8'hFF;

    // Leading-zero pattern {0,0,0,0,0,1,0,3}
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i);
      wr_data = (i == 0) ? 5'h03 : (i == 2) ? 5'h01 : 5'h00;
      step();
    end
    wr_en = 1'b0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    repeat (90) step();

    // Asynchronous reset mid-scan
    rst_n = 1'b0;
    #1;
    check("arst_sel", sel, 8'hFF);
    check("arst_seg", seg, 8'hFF);
    check("arst_pend", {7'd0, commit_pend}, 8'd0);
    model_reset();
    @(posedge clks); #1;
    rst_n = 1'b1;
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
